dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and port 1 of the 128-bit-block main memory. It serves 32-bit word accesses with byte enables on hits in the same cycle. On a miss it writes back a dirty victim block if needed, then fetches the missing 128-bit block. Exactly one request per memory access is issued, matching the memory's registered one-cycle Valid→Ready behaviour.

---
 rtl/dcache.sv | 120 ++++++++++++
 tb/tb_dcache.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache: hits complete combinationally,
// misses write back a dirty victim and then fetch the 128-bit block.
module dcache #(
  parameter int SETS = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cpu_valid_i,
  input  logic         cpu_wen_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [3:0]   cpu_be_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic         cpu_ready_o,
  output logic [31:0]  cpu_rdata_o,
  output logic         mem_valid_o,
  output logic         mem_wen_o,
  output logic [31:0]  mem_raddr_o,
  output logic [31:0]  mem_waddr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [127:0] mem_rdata_i
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;

  typedef enum logic [2:0] {COMPARE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT} state_t;

  state_t         state;
  logic [SETS-1:0] valid, dirty;
  logic [TW-1:0]  tags [SETS];
  logic [127:0]   data [SETS];

  logic [IW-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [1:0]     wsel;
  logic [127:0]   line, merged;
  logic           hit, store_hit, fill;
  wire            unused_ok = ^cpu_addr_i[1:0];

  assign idx  = cpu_addr_i[IW+3:4];
  assign tag  = cpu_addr_i[31:IW+4];
  assign wsel = cpu_addr_i[3:2];
  assign line = data[idx];
  assign hit  = cpu_valid_i & valid[idx] & (tags[idx] == tag);

  assign cpu_ready_o = (state == COMPARE) & hit;
  assign cpu_rdata_o = (cpu_ready_o & ~cpu_wen_i) ? line[wsel*32 +: 32] : 32'h0;
  assign store_hit   = cpu_ready_o & cpu_wen_i;
  assign fill        = (state == AL_WAIT) & mem_ready_i;

  // Victim fields come from the line the current request indexes.
  assign mem_raddr_o = {cpu_addr_i[31:4], 4'h0};
  assign mem_waddr_o = {tags[idx], idx, 4'h0};
  assign mem_wdata_o = line;

  always_comb begin
    merged = line;
    for (int b = 0; b < 4; b++)
      if (cpu_be_i[b]) merged[wsel*32 + b*8 +: 8] = cpu_wdata_i[b*8 +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= COMPARE;
      valid       <= '0;
      dirty       <= '0;
      mem_valid_o <= 1'b0;
      mem_wen_o   <= 1'b0;
    end else begin
      case (state)
        COMPARE: begin
          if (store_hit) dirty[idx] <= 1'b1;
          if (cpu_valid_i && !hit) begin
            mem_valid_o <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state     <= WB_REQ;
              mem_wen_o <= 1'b1;
            end else begin
              state     <= AL_REQ;
              mem_wen_o <= 1'b0;
            end
          end
        end
        WB_REQ: begin
          state       <= WB_WAIT;
          mem_valid_o <= 1'b0;
          mem_wen_o   <= 1'b0;
        end
        WB_WAIT: if (mem_ready_i) begin
          state       <= AL_REQ;
          mem_valid_o <= 1'b1;
        end
        AL_REQ: begin
          state       <= AL_WAIT;
          mem_valid_o <= 1'b0;
        end
        AL_WAIT: if (mem_ready_i) begin
          state      <= COMPARE;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: begin
          state       <= COMPARE;
          mem_valid_o <= 1'b0;
          mem_wen_o   <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data[idx] <= mem_rdata_i;
      tags[idx] <= tag;
    end else if (store_hit) begin
      data[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache: CPU-visible memory model plus per-set residency model
// predicts load data, completion latency and memory request counts.
module tb_dcache;
  localparam int SETS = 16;

  logic         clk_i = 0, rst_ni = 0;
  logic         cpu_valid_i = 0, cpu_wen_i = 0;
  logic [31:0]  cpu_addr_i = 0, cpu_wdata_i = 0;
  logic [3:0]   cpu_be_i = 0;
  logic         cpu_ready_o, mem_valid_o, mem_wen_o;
  logic [31:0]  cpu_rdata_o, mem_raddr_o, mem_waddr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i = 0;
  logic [127:0] mem_rdata_i = 0;

  dcache #(.SETS(SETS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cpu_valid_i(cpu_valid_i), .cpu_wen_i(cpu_wen_i),
    .cpu_addr_i(cpu_addr_i), .cpu_be_i(cpu_be_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o), .mem_valid_o(mem_valid_o),
    .mem_wen_o(mem_wen_o), .mem_raddr_o(mem_raddr_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  task automatic chk(input string tg, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tg, got, exp);
    end
  endtask

  // Backing memory (what the DUT has written back) and CPU-visible view.
  logic [127:0] mem  [bit [31:0]];
  logic [127:0] refm [bit [31:0]];

  function automatic logic [127:0] init_blk(bit [31:0] a);
    return {a ^ 32'hA5A5_0003, ~a, a * 32'd2654435761, a ^ 32'h1234_5678};
  endfunction
  function automatic logic [127:0] mem_rd(bit [31:0] a);
    if (!mem.exists(a)) mem[a] = init_blk(a);
    return mem[a];
  endfunction
  function automatic logic [127:0] ref_rd(bit [31:0] a);
    if (!refm.exists(a)) refm[a] = init_blk(a);
    return refm[a];
  endfunction

  // Memory port: Ready one cycle after the Valid cycle, plus ext extra cycles.
  int busy = 0, cnt = 0, ext = 0, nreq = 0;
  bit [31:0] last_raddr = 0, last_waddr = 0;
  logic [127:0] last_wdata = 0;
  always @(negedge clk_i) begin
    mem_ready_i = 1'b0;
    if (busy != 0) begin
      if (cnt == 0) begin mem_ready_i = 1'b1; busy = 0; end
      else cnt--;
    end
    if (mem_valid_o) begin
      nreq++;
      busy = 1;
      cnt  = ext;
      if (mem_wen_o) begin
        mem[mem_waddr_o] = mem_wdata_o;
        last_waddr = mem_waddr_o;
        last_wdata = mem_wdata_o;
      end else begin
        last_raddr  = mem_raddr_o;
        mem_rdata_i = mem_rd(mem_raddr_o);
      end
    end
  end

  // Residency model: which block each set holds and whether it is modified.
  bit        mv [SETS];
  bit        md [SETS];
  bit [23:0] mt [SETS];
  logic [31:0] last_got;

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) begin mv[s] = 0; md[s] = 0; mt[s] = 0; end
  endtask

  // Called at a negedge; returns at a negedge with the request retired.
  task automatic access(input bit w, input bit [31:0] a, input bit [3:0] be,
                        input bit [31:0] d, input string tg);
    int idx, exp_lat, exp_req, lat, n0;
    bit [23:0] t;
    bit [31:0] blk;
    logic [127:0] b;
    idx = int'(a[7:4]);
    t   = a[31:8];
    blk = {a[31:4], 4'h0};
    if (mv[idx] && mt[idx] == t) begin exp_lat = 0; exp_req = 0; end
    else if (mv[idx] && md[idx]) begin exp_lat = 5 + 2*ext; exp_req = 2; end
    else begin exp_lat = 3 + ext; exp_req = 1; end
    n0 = nreq;
    cpu_valid_i = 1; cpu_wen_i = w; cpu_addr_i = a; cpu_be_i = be; cpu_wdata_i = d;
    lat = 0;
    #1;
    while (!cpu_ready_o && lat < 60) begin
      @(negedge clk_i); lat++; #1;
    end
    last_got = cpu_rdata_o;
    @(posedge clk_i);
    @(negedge clk_i);
    cpu_valid_i = 0;
    chk({tg, "_lat"}, lat, exp_lat);
    chk({tg, "_nreq"}, nreq - n0, exp_req);
    b = ref_rd(blk);
    if (!w) chk({tg, "_rdata"}, last_got, b[a[3:2]*32 +: 32]);
    else begin
      chk({tg, "_st_rdata"}, last_got, 32'h0);
      for (int k = 0; k < 4; k++)
        if (be[k]) b[a[3:2]*32 + k*8 +: 8] = d[k*8 +: 8];
      refm[blk] = b;
    end
    md[idx] = w ? 1'b1 : ((mv[idx] && mt[idx] == t) ? md[idx] : 1'b0);
    mv[idx] = 1;
    mt[idx] = t;
  endtask

  task automatic chk_idle(input string tg);
    chk({tg, "_ready"}, cpu_ready_o, 1'b0);
    chk({tg, "_rdata"}, cpu_rdata_o, 32'h0);
    chk({tg, "_mvalid"}, mem_valid_o, 1'b0);
    chk({tg, "_mwen"}, mem_wen_o, 1'b0);
  endtask

  initial begin
    clear_model();
    mem[32'h0001_0000]  = 128'hFFFFEEEE_DDDDCCCC_BBBBAAAA_99998888;
    refm[32'h0001_0000] = 128'hFFFFEEEE_DDDDCCCC_BBBBAAAA_99998888;
    repeat (3) @(negedge clk_i);
    chk_idle("rst");
    rst_ni = 1;
    @(negedge clk_i);

    access(0, 32'h0001_0004, 4'h0, 0, "fill");
    chk("fill_raddr", last_raddr, 32'h0001_0000);
    chk("fill_word", last_got, 32'hBBBBAAAA);
    access(1, 32'h0001_0004, 4'b0011, 32'hDEADBEEF, "st_hit");
    access(0, 32'h0001_0004, 4'h0, 0, "ld_merged");
    chk("merged_word", last_got, 32'hBBBBBEEF);

    access(0, 32'h0001_0100, 4'h0, 0, "dirty_miss");
    chk("wb_addr", last_waddr, 32'h0001_0000);
    chk("wb_data", last_wdata, 128'hFFFFEEEE_DDDDCCCC_BBBBBEEF_99998888);
    chk("dm_raddr", last_raddr, 32'h0001_0100);

    ext = 3;
    access(0, 32'h0001_0208, 4'h0, 0, "slow_fill");
    ext = 0;

    access(0, 32'h0001_0210, 4'h0, 0, "fill_b");
    for (int i = 0; i < 8; i++)
      access(0, (i % 2 == 0) ? 32'h0001_0200 + 32'(i/2)*4 : 32'h0001_0210 + 32'(i/2)*4,
             4'h0, 0, "b2b");

    // Reset during the write-back wait of a dirty miss.
    access(1, 32'h0001_0214, 4'b1111, 32'hCAFEF00D, "pre_rst_st");
    cpu_valid_i = 1; cpu_wen_i = 0; cpu_addr_i = 32'h0001_0310;
    @(posedge clk_i); #1;
    chk("wbreq_wen", mem_wen_o, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 0;
    #1;
    chk_idle("mid_rst");
    cpu_valid_i = 0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1;
    refm = mem;
    clear_model();
    @(negedge clk_i);
    access(0, 32'h0001_0214, 4'h0, 0, "post_rst");

    for (int n = 0; n < 400; n++) begin
      bit [31:0] a;
      a = 32'h0004_0000 | (32'($urandom % 3) << 8) | (32'($urandom % 16) << 4) |
          (32'($urandom % 4) << 2) | 32'($urandom % 4);
      ext = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
      access($urandom % 2 == 0, a, 4'($urandom), $urandom, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
